// File: rtl/tx_block_distributor.sv
// tx_block_distributor: deals 66b blocks round-robin onto PCS lanes and
// periodically inserts a round of per-lane alignment markers carrying BIP3.
`timescale 1ns/1ps
module tx_block_distributor #(
  parameter int NB_DATA     = 66,
  parameter int N_LANES     = 20,
  parameter int AM_PERIOD   = 16383,
  parameter int NB_LANE_CNT = $clog2(N_LANES),
  parameter int NB_AM_CNT   = $clog2(AM_PERIOD),
  parameter int NB_DATA_BUS = N_LANES*NB_DATA,
  parameter int NB_AM_BUS   = N_LANES*24
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic [NB_DATA-1:0]     i_data,
  input  logic [NB_AM_BUS-1:0]   i_rf_am_values,
  output logic                   o_ready,
  output logic [NB_DATA_BUS-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_am_flag
);
  typedef enum logic {AM_FILL, DATA} state_t;
  state_t state;
  logic [NB_LANE_CNT-1:0] slot_cnt;
  logic [NB_AM_CNT-1:0] round_cnt;
  logic [NB_DATA-1:0] lanes [N_LANES];
  logic [NB_DATA-1:0] pub [N_LANES];
  logic [7:0] acc [N_LANES];
  logic [7:0] acc_nxt [N_LANES];
  logic slot, wrap;
  // Bit j covers transmit bits j+2+8m, i.e. vector bits 63-j-8m; the sync header feeds bits 3 and 4.
  function automatic logic [7:0] bip(input logic [NB_DATA-1:0] b);
    logic [7:0] p;
    p = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        p[j] = p[j] ^ b[63-j-8*i];
    p[3] = p[3] ^ b[65];
    p[4] = p[4] ^ b[64];
    return p;
  endfunction
  assign slot    = i_enable && i_valid;
  assign wrap    = slot_cnt == NB_LANE_CNT'(N_LANES-1);
  assign o_ready = state == DATA;
  // The last lane's block arrives on the wrap slot itself, so it bypasses the lane buffer.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [23:0] m;
    logic [NB_DATA-1:0] am_blk, data_blk;
    assign m           = i_rf_am_values[k*24 +: 24];
    assign am_blk      = {2'b10, m, acc[k], ~m, ~acc[k]};
    assign data_blk    = k == N_LANES-1 ? i_data : lanes[k];
    assign pub[k]      = state == AM_FILL ? am_blk : data_blk;
    assign acc_nxt[k]  = state == AM_FILL ? bip(am_blk) : acc[k] ^ bip(data_blk);
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state     <= AM_FILL;
      slot_cnt  <= '0;
      round_cnt <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_am_flag <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        lanes[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      o_valid   <= 1'b0;
      o_am_flag <= 1'b0;
      if (slot) begin
        slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
        if (state == DATA) lanes[slot_cnt] <= i_data;
        if (wrap) begin
          o_valid   <= 1'b1;
          o_am_flag <= state == AM_FILL;
          for (int i = 0; i < N_LANES; i++) begin
            o_data[i*NB_DATA +: NB_DATA] <= pub[i];
            acc[i] <= acc_nxt[i];
          end
          if (state == AM_FILL) state <= DATA;
          else if (round_cnt == NB_AM_CNT'(AM_PERIOD-1)) begin
            state     <= AM_FILL;
            round_cnt <= '0;
          end else round_cnt <= round_cnt + 1'b1;
        end
      end
    end
endmodule

// File: doc/tx_block_distributor.md
# tx_block_distributor

Transmit-side PCS lane distribution block for the 100GbE PCS: takes the serial stream of 66-bit encoded blocks and deals them round-robin onto N_LANES PCS lanes. It periodically replaces one full round with per-lane alignment markers carrying a BIP3 parity computed per lane. The output lane bus feeds the TX lane/serializer path and is what the RX deskew and lane-reorder chain locks onto.

## Interface
- NB_DATA, 66, block width (sync header + payload)
- N_LANES, 20, number of PCS lanes
- AM_PERIOD, 16383, data rounds between alignment-marker rounds
- NB_LANE_CNT, $clog2(N_LANES), lane/slot counter width
- NB_AM_CNT, $clog2(AM_PERIOD), round counter width
- NB_DATA_BUS, N_LANES*NB_DATA, output bus width
- NB_AM_BUS, N_LANES*24, marker value bus width
- i_clock  in  1  single clock
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  global enable; low freezes all state
- i_valid  in  1  clock-enable qualifier; a slot exists only when i_enable && i_valid
- i_data  in  NB_DATA  encoded block, sync header in [65:64], first-transmitted bit at [65]
- i_rf_am_values  in  NB_AM_BUS  lane k {M0,M1,M2} at [k*24 +: 24], M0 in MSBs
- o_ready  out  1  block at i_data is accepted in this slot
- o_data  out  NB_DATA_BUS  lane k block at [k*NB_DATA +: NB_DATA]
- o_valid  out  1  one-cycle strobe: o_data holds a new full round
- o_am_flag  out  1  qualifies o_valid: round is an alignment-marker round

## Operation
- Slot = cycle with i_enable && i_valid. All state advances only on slots; i_enable low or i_valid low holds everything, including o_valid low.
- Two states. AM_FILL: o_ready=0, slot counter counts N_LANES slots, input ignored. DATA: o_ready=1, each slot's i_data is written into lane[slot_cnt], counter increments.
- Reset state AM_FILL, so the first round emitted after reset is an AM round.
- Slot counter wraps at N_LANES-1 -> 0. On the wrap, the round is published. In DATA, round_cnt increments. When round_cnt reaches AM_PERIOD-1 on a wrap, the state goes to AM_FILL and round_cnt is cleared. AM_FILL always returns to DATA on its wrap.
- AM block for lane k: header 2'b10, then from [63:0] {M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3}.
- BIP3 accumulator, 8 bits per lane, per IEEE 802.3 clause 82.2.8:
  - Let t = transmit bit index, t=0 at vector bit 65.
  - BIP bit j (j=0..7) = XOR of bits t = j+2+8m for m=0..7.
  - In addition, bit 3 includes t=0 and bit 4 includes t=1.
  - Every block published on lane k, both data and AM, is XORed into acc[k].
  - When an AM round is built, BIP3 = acc[k] before that AM is folded in. acc[k] is then reloaded with the parity of the AM block itself.
  - acc resets to 0, so the first AM round has BIP3=0x00 and BIP7=0xFF.
- Published round is held in an output register, stable until the next publish.
- Reset mid-operation clears the partial round, counters, accumulators and state immediately; blocks not yet published are discarded.

## Timing
- Reset values: o_ready=0, o_data=0, o_valid=0, o_am_flag=0.
- Latency: publish occurs on the clock edge of the wrapping slot. o_valid and o_am_flag are high in the following cycle for exactly one cycle, and o_data is updated on that same edge.
- o_ready is registered-state driven (function of state only). It changes only on the edge of a wrapping slot and is never combinationally dependent on i_valid.
- Steady state: N_LANES*AM_PERIOD accepted blocks, then exactly N_LANES slots with o_ready=0.
- The next round starts filling in the slot after the wrap; there are no bubbles.
- i_rf_am_values is sampled on the wrap slot of AM_FILL.

## Test plan
- Reset -> all outputs 0, o_ready=0. Then 20 slots -> o_valid=o_am_flag=1 one cycle. Lane 0 = 2'b10, 64'hC16821_00_3E97DE_FF for i_rf_am_values lane 0 = 24'hC16821. o_ready rises on the same edge.
- DATA: feed blocks with value k on slots k=0..19 -> o_data lane k = k, o_valid one cycle, o_am_flag=0. Latency 1 cycle after the 20th slot.
- AM_PERIOD=4, random data -> exactly 80 accepted blocks, then o_ready=0 for exactly 20 slots. AM round BIP3 per lane matches a reference model that includes the previous AM.
- i_valid toggling 50% plus i_enable low for 7 cycles mid-round -> lane contents and ordering identical to a gap-free run, and o_valid never asserts in gap cycles.
- Assert i_reset mid-round (slot 11 of a DATA round) -> outputs clear asynchronously. Next publish is an AM round with BIP3=0x00 after 20 slots.
